// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode and sizing constants for the SPI master/slave pair
//
// Purpose: single source of truth for the link's clock mode and default sizing.
//   SPI_CPOL / SPI_CPHA : SCL idles low, data sampled on the falling SCL edge
//   SPI_DATA_W          : default word width in bits
//   SPI_SYNC_STAGES     : default synchronizer depth for the SPI pins
package spi_pkg;

  localparam int SPI_CPOL        = 0;
  localparam int SPI_CPHA        = 1;
  localparam int SPI_DATA_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-stage synchronizer with edge detection
//
// Purpose: brings an asynchronous pin into the clk domain and flags its edges.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-low reset, presets every flop to RST_VAL
//   d_i    : asynchronous input pin
//   q_o    : synchronized level
//   rise_o : synchronized level went 0 -> 1 this cycle
//   fall_o : synchronized level went 1 -> 0 this cycle
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // prev_q is preset to the same idle level as the chain so that no edge can
  // be reported in the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI slave receiver (CPOL 0, CPHA 1, MSB first)
//
// Purpose: oversamples SCL/SS/MOSI on clk, assembles DATA_W-bit words and hands
// them downstream through a single holding register with valid/ready.
// Ports:
//   clk, rst          : system clock, synchronous active-low reset
//   SCL, SS, MOSI     : asynchronous SPI pins from the master
//   rx_data, rx_valid : holding register contents and occupancy
//   rx_ready          : downstream consumes rx_data when rx_valid && rx_ready
//   err_clr           : clears the sticky overrun / frame_err flags
//   overrun           : a word completed while the holding register was full
//   frame_err         : SS deasserted part-way through a word
//   busy              : synchronized SS is low
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCL,
  input  logic              SS,
  input  logic              MOSI,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              err_clr,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic scl_s, scl_rise, scl_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_scl (
    .clk(clk), .rst(rst), .d_i(SCL), .q_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d_i(SS), .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(MOSI), .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  // Rising SCL, falling SS and MOSI edges carry no meaning in this mode.
  logic unused_edges;
  assign unused_edges = ^{scl_s, scl_rise, ss_fall, mosi_rise, mosi_fall};

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic              sample;
  logic              complete;
  logic [DATA_W-1:0] word;

  assign sample   = scl_fall && !ss_s;
  assign complete = sample && (bit_cnt_q == LAST_BIT);
  assign word     = {shift_q[DATA_W-2:0], mosi_s};

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;

    if (err_clr) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end

    // Deselected: counter parked at zero, shifter frozen. A deselect that
    // lands mid-word is a framing error; the partial bits are simply left to
    // be shifted out by the next full word.
    if (ss_s) begin
      bit_cnt_d = '0;
      if (ss_rise && (bit_cnt_q != '0)) begin
        frame_err_d = 1'b1;
      end
    end else if (sample) begin
      shift_d   = word;
      bit_cnt_d = complete ? '0 : bit_cnt_q + 1'b1;
    end

    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = word;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = ~ss_s;

endmodule
